// File: rtl/ex_mem_cond_stage_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the EX/MEM boundary
// and any other stage that evaluates ARM-style condition fields.
package ex_mem_cond_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_mem_cond_stage_cond_check.sv
// Combinational condition evaluator: decides whether a 4-bit condition field
// passes against an NZCV flag vector. Also used by the decode-stage predictor.
module cond_check
    import ex_mem_cond_stage_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            // AL and the unused 1111 encoding both always execute
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_cond_stage.sv
// EX->MEM boundary: owns the architectural NZCV register, gates side effects by
// the EX condition result, and carries result/store data/controls into MEM.
module ex_mem_cond_stage
    import ex_mem_cond_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int RAW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ValidE,
    input  logic [DW-1:0]  ALUResultE,
    input  logic [3:0]     ALUFlagsE,
    input  logic [DW-1:0]  WriteDataE,
    input  logic [RAW-1:0] WA3E,
    input  logic [3:0]     CondE,
    input  logic [1:0]     FlagWE,
    input  logic           RegWriteE,
    input  logic           MemWriteE,
    input  logic           MemtoRegE,
    input  logic           BranchE,
    input  logic           StallM,
    input  logic           FlushM,
    output logic           CondExE,
    output logic           PCSrcE,
    output logic [3:0]     Flags,
    output logic           ValidM,
    output logic [DW-1:0]  ALUResultM,
    output logic [DW-1:0]  WriteDataM,
    output logic [RAW-1:0] WA3M,
    output logic           RegWriteM,
    output logic           MemWriteM,
    output logic           MemtoRegM
);

    logic go;
    logic adv;

    // Condition is judged against committed Flags only; the flag producer is
    // always at least one stage ahead, so no bypass path is needed.
    cond_check u_cond_check (
        .Cond   (CondE),
        .Flags  (Flags),
        .CondEx (CondExE)
    );

    assign go     = ValidE & CondExE;
    assign adv    = ~StallM & ~FlushM;
    assign PCSrcE = BranchE & go;

    // Flag commit: a stalled or flushed instruction must not update flags, so a
    // stalled flag-setter commits exactly once, on the edge it finally advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else if (adv && go) begin
            if (FlagWE[1]) begin
                Flags[FLAG_N] <= ALUFlagsE[FLAG_N];
                Flags[FLAG_Z] <= ALUFlagsE[FLAG_Z];
            end
            if (FlagWE[0]) begin
                Flags[FLAG_C] <= ALUFlagsE[FLAG_C];
                Flags[FLAG_V] <= ALUFlagsE[FLAG_V];
            end
        end
    end

    // EX -> MEM register; flush takes priority over stall
    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (!StallM) begin
            ValidM     <= ValidE;
            RegWriteM  <= RegWriteE & go;
            MemWriteM  <= MemWriteE & go;
            MemtoRegM  <= MemtoRegE & go;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
        end
    end

endmodule

// File: tb/tb_ex_mem_cond_stage.sv
// Self-checking bench for ex_mem_cond_stage: directed scenarios plus random traffic
// compared against a behavioural model of flags and the MEM slot.
module tb_ex_mem_cond_stage;

    localparam int DW  = 32;
    localparam int RAW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           ValidE;
    logic [DW-1:0]  ALUResultE;
    logic [3:0]     ALUFlagsE;
    logic [DW-1:0]  WriteDataE;
    logic [RAW-1:0] WA3E;
    logic [3:0]     CondE;
    logic [1:0]     FlagWE;
    logic           RegWriteE, MemWriteE, MemtoRegE, BranchE, StallM, FlushM;
    logic           CondExE, PCSrcE, ValidM, RegWriteM, MemWriteM, MemtoRegM;
    logic [3:0]     Flags;
    logic [DW-1:0]  ALUResultM, WriteDataM;
    logic [RAW-1:0] WA3M;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [3:0]     m_flags;
    logic           m_validm, m_rw, m_mw, m_m2r;
    logic [DW-1:0]  m_alu, m_wd;
    logic [RAW-1:0] m_wa3;

    ex_mem_cond_stage #(.DW(DW), .RAW(RAW)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .ALUResultE(ALUResultE),
        .ALUFlagsE(ALUFlagsE), .WriteDataE(WriteDataE), .WA3E(WA3E), .CondE(CondE),
        .FlagWE(FlagWE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .BranchE(BranchE), .StallM(StallM), .FlushM(FlushM),
        .CondExE(CondExE), .PCSrcE(PCSrcE), .Flags(Flags), .ValidM(ValidM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pairs of conditions: even encoding is the base test, odd is its negation
    // (except 1111, which always executes).
    function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'b1111) return 1'b1;
        return cond[0] ? !base : base;
    endfunction

    task automatic idle_inputs();
        reset = 0; ValidE = 0; ALUResultE = '0; ALUFlagsE = '0; WriteDataE = '0;
        WA3E = '0; CondE = 4'b1110; FlagWE = 2'b00; RegWriteE = 0; MemWriteE = 0;
        MemtoRegE = 0; BranchE = 0; StallM = 0; FlushM = 0;
    endtask

    // One clock with the currently driven inputs; checks comb outputs before the
    // edge and registered outputs after it, against the model.
    task automatic cycle();
        bit pass, go;
        @(negedge clk);
        pass = ref_cond(CondE, m_flags);
        check_eq("condex", CondExE, pass);
        check_eq("pcsrc", PCSrcE, BranchE && ValidE && pass);
        @(posedge clk);
        go = ValidE && pass;
        if (reset) begin
            m_flags = 0; m_validm = 0; m_rw = 0; m_mw = 0; m_m2r = 0;
            m_alu = 0; m_wd = 0; m_wa3 = 0;
        end else begin
            if (!StallM && !FlushM && go) begin
                if (FlagWE[1]) m_flags[3:2] = ALUFlagsE[3:2];
                if (FlagWE[0]) m_flags[1:0] = ALUFlagsE[1:0];
            end
            if (FlushM) begin
                m_validm = 0; m_rw = 0; m_mw = 0; m_m2r = 0;
                m_alu = 0; m_wd = 0; m_wa3 = 0;
            end else if (!StallM) begin
                m_validm = ValidE; m_rw = RegWriteE && go; m_mw = MemWriteE && go;
                m_m2r = MemtoRegE && go; m_alu = ALUResultE; m_wd = WriteDataE;
                m_wa3 = WA3E;
            end
        end
        #1;
        check_eq("flags", Flags, m_flags);
        check_eq("validm", ValidM, m_validm);
        check_eq("regwritem", RegWriteM, m_rw);
        check_eq("memwritem", MemWriteM, m_mw);
        check_eq("memtoregm", MemtoRegM, m_m2r);
        check_eq("aluresultm", ALUResultM, m_alu);
        check_eq("writedatam", WriteDataM, m_wd);
        check_eq("wa3m", WA3M, m_wa3);
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle_inputs();
        ValidE = 1; CondE = 4'b1110; FlagWE = 2'b11; ALUFlagsE = f;
        cycle();
    endtask

    initial begin
        m_flags = 4'hf; m_validm = 1; m_rw = 1; m_mw = 1; m_m2r = 1;
        m_alu = '1; m_wd = '1; m_wa3 = '1;
        idle_inputs();
        reset = 1;
        ValidE = 1; RegWriteE = 1; FlagWE = 2'b11; ALUFlagsE = 4'hf;
        cycle();
        cycle();
        check_eq("rst_flags", Flags, 4'b0000);
        check_eq("rst_validm", ValidM, 1'b0);
        check_eq("rst_alu", ALUResultM, 32'h0);

        // 1: AL instruction sets all flags
        idle_inputs();
        ValidE = 1; CondE = 4'b1110; FlagWE = 2'b11; ALUFlagsE = 4'b0110;
        RegWriteE = 1; ALUResultE = 32'h1234_5678;
        cycle();
        check_eq("t1_flags", Flags, 4'b0110);
        check_eq("t1_validm", ValidM, 1'b1);
        check_eq("t1_regwrite", RegWriteM, 1'b1);
        check_eq("t1_alu", ALUResultM, 32'h1234_5678);

        // 2: NE fails with Z set -> valid bubble with no writes, flags untouched
        load_flags(4'b0100);
        idle_inputs();
        ValidE = 1; CondE = 4'b0001; RegWriteE = 1; MemWriteE = 1; FlagWE = 2'b11;
        ALUFlagsE = 4'b1011;
        #1 check_eq("t2_condex", CondExE, 1'b0);
        cycle();
        check_eq("t2_regwrite", RegWriteM, 1'b0);
        check_eq("t2_memwrite", MemWriteM, 1'b0);
        check_eq("t2_validm", ValidM, 1'b1);
        check_eq("t2_flags", Flags, 4'b0100);

        // 3: stalled flag-setter commits once after release
        idle_inputs();
        ValidE = 1; CondE = 4'b1110; FlagWE = 2'b01; ALUFlagsE = 4'b0011;
        RegWriteE = 1; WA3E = 4'h9; StallM = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t3_frozen_flags", Flags, 4'b0100);
            check_eq("t3_frozen_wa3", WA3M, 4'h0);
        end
        StallM = 0;
        cycle();
        check_eq("t3_release_flags", Flags, 4'b0111);
        check_eq("t3_release_wa3", WA3M, 4'h9);
        FlagWE = 2'b00;
        cycle();
        check_eq("t3_hold_flags", Flags, 4'b0111);

        // 4: flush and stall together -> bubble, no flag update
        idle_inputs();
        FlushM = 1; StallM = 1; ValidE = 1; RegWriteE = 1; FlagWE = 2'b11;
        ALUFlagsE = 4'b1000;
        cycle();
        check_eq("t4_validm", ValidM, 1'b0);
        check_eq("t4_regwrite", RegWriteM, 1'b0);
        check_eq("t4_flags", Flags, 4'b0111);

        // 5: full decode table sweep
        for (int f = 0; f < 16; f++) begin
            load_flags(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                CondE = c[3:0]; BranchE = 1; FlagWE = 2'b00;
                ValidE = $urandom_range(0, 1);
                #1;
                check_eq("t5_condex", CondExE, ref_cond(c[3:0], f[3:0]));
                check_eq("t5_pcsrc", PCSrcE, ValidE && ref_cond(c[3:0], f[3:0]));
            end
            CondE = 4'b1110;
            cycle();
        end

        // 6: ADDS sets Z, then BEQ in the next EX cycle; then reset mid-stream
        load_flags(4'b0000);
        idle_inputs();
        ValidE = 1; CondE = 4'b1110; FlagWE = 2'b11; ALUFlagsE = 4'b0100; RegWriteE = 1;
        cycle();
        idle_inputs();
        ValidE = 1; CondE = 4'b0000; BranchE = 1;
        #1 check_eq("t6_pcsrc", PCSrcE, 1'b1);
        cycle();
        reset = 1;
        cycle();
        check_eq("t6_rst_validm", ValidM, 1'b0);
        check_eq("t6_rst_flags", Flags, 4'b0000);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            ValidE     = ($urandom_range(0, 3) != 0);
            ALUResultE = $urandom;
            WriteDataE = $urandom;
            ALUFlagsE  = $urandom_range(0, 15);
            WA3E       = $urandom_range(0, 15);
            CondE      = $urandom_range(0, 15);
            FlagWE     = $urandom_range(0, 3);
            RegWriteE  = $urandom_range(0, 1);
            MemWriteE  = $urandom_range(0, 1);
            MemtoRegE  = $urandom_range(0, 1);
            BranchE    = $urandom_range(0, 1);
            StallM     = ($urandom_range(0, 4) == 0);
            FlushM     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
